// File: rtl/match_ctrl.sv
// Match sequencing for a two-player ball game: serve timing, speed ramp,
// goal detection from ball column wrap, scoring and match end.
module match_ctrl #(
   parameter int SERVE_DELAY = 2000,
   parameter int RAMP_PERIOD = 4000,
   parameter int BASE_SPEED  = 4,
   parameter int MAX_SPEED   = 15,
   parameter int WIN_SCORE   = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        ball_x,
   output logic              ball_reset,
   output logic signed [4:0] speed,
   output logic [3:0]        lscore,
   output logic [3:0]        rscore,
   output logic              game_over,
   output logic              winner
);

   typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  mag_q, mag_d;
   logic        dir_q, dir_d;
   logic [3:0]  ls_q, ls_d, rs_q, rs_d;
   logic [3:0]  prev_x_q;
   logic        start_q, armed_q;
   logic        br_q, br_d, go_q, go_d, win_q, win_d;
   logic [4:0]  speed_q, speed_d;
   logic [4:0]  magx;
   logic        start_edge, left_goal, right_goal;

   // armed_q requires start to be seen low after reset, so a button held
   // through reset cannot launch a match.
   assign start_edge = start & ~start_q & armed_q;
   assign left_goal  = (prev_x_q == 4'd15) && (ball_x == 4'd0);
   assign right_goal = (prev_x_q == 4'd0)  && (ball_x == 4'd15);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      dir_d   = dir_q;
      ls_d    = ls_q;
      rs_d    = rs_q;
      case (state_q)
         IDLE, OVER: begin
            if (start_edge) begin
               ls_d    = 4'd0;
               rs_d    = 4'd0;
               dir_d   = 1'b1;
               cnt_d   = 16'd0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (cnt_q == 16'(SERVE_DELAY - 1)) begin
               cnt_d   = 16'd0;
               mag_d   = 4'(BASE_SPEED);
               state_d = PLAY;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         PLAY: begin
            if (left_goal) begin
               rs_d    = rs_q + 4'd1;
               dir_d   = 1'b1;
               cnt_d   = 16'd0;
               state_d = POINT;
            end else if (right_goal) begin
               ls_d    = ls_q + 4'd1;
               dir_d   = 1'b0;
               cnt_d   = 16'd0;
               state_d = POINT;
            end else if (cnt_q == 16'(RAMP_PERIOD - 1)) begin
               cnt_d = 16'd0;
               if (mag_q < 4'(MAX_SPEED)) mag_d = mag_q + 4'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         POINT: begin
            cnt_d = 16'd0;
            if (ls_q == 4'(WIN_SCORE) || rs_q == 4'(WIN_SCORE)) state_d = OVER;
            else                                                 state_d = SERVE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state values so they align with state_q.
      magx    = {1'b0, mag_d};
      br_d    = (state_d != PLAY);
      speed_d = 5'd0;
      if (state_d == PLAY) speed_d = dir_d ? magx : (5'd0 - magx);
      go_d    = (state_d == OVER);
      win_d   = go_d && (ls_d == 4'(WIN_SCORE));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 16'd0;
         mag_q    <= 4'd0;
         dir_q    <= 1'b1;
         ls_q     <= 4'd0;
         rs_q     <= 4'd0;
         prev_x_q <= 4'd8;
         start_q  <= 1'b0;
         armed_q  <= 1'b0;
         br_q     <= 1'b1;
         speed_q  <= 5'd0;
         go_q     <= 1'b0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mag_q    <= mag_d;
         dir_q    <= dir_d;
         ls_q     <= ls_d;
         rs_q     <= rs_d;
         prev_x_q <= ball_x;
         start_q  <= start;
         if (!start) armed_q <= 1'b1;
         br_q     <= br_d;
         speed_q  <= speed_d;
         go_q     <= go_d;
         win_q    <= win_d;
      end
   end

   assign ball_reset = br_q;
   assign speed      = speed_q;
   assign lscore     = ls_q;
   assign rscore     = rs_q;
   assign game_over  = go_q;
   assign winner     = win_q;

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter SERVE_DELAY, default 2000: clock cycles ball is held at centre before each serve (1 s at 2000 Hz); range 1..65535.
REQ-002 Parameter RAMP_PERIOD, default 4000: PLAY cycles between speed increments; range 1..65535.
REQ-003 Parameter BASE_SPEED, default 4: serve speed magnitude; range 1..MAX_SPEED.
REQ-004 Parameter MAX_SPEED, default 15: speed magnitude ceiling; range BASE_SPEED..15.
REQ-005 Parameter WIN_SCORE, default 9: points that end the match; range 1..15.
REQ-006 clk  input  1  game clock, 2000 Hz nominal; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level from start button; only its rising edge is used.
REQ-009 ball_x  input  4  ball column from the ball block; column 15 = left paddle side, column 0 = right paddle side.
REQ-010 ball_reset  output  1  registered; drives the ball block's reset (ball to centre, theta 0).
REQ-011 speed  output  5  registered, signed; ball speed; positive moves toward column 15 (left).
REQ-012 lscore  output  4  registered; left player score.
REQ-013 rscore  output  4  registered; right player score.
REQ-014 game_over  output  1  registered; high only in OVER.
REQ-015 winner  output  1  registered; 1 = left won, 0 = right won; valid while game_over = 1.

Function
REQ-016 FSM states: IDLE, SERVE, PLAY, POINT, OVER; state register and all outputs update only on the rising edge of clk.
REQ-017 Rising edge of start = start high this cycle AND low in the previous cycle, using a one-cycle delayed copy of start; the delayed copy is cleared to 0 by reset.
REQ-018 IDLE: ball_reset = 1, speed = 0. A start edge clears lscore/rscore, sets serve_dir = +, and moves to SERVE on the next cycle.
REQ-019 SERVE: ball_reset = 1, speed = 0, for exactly SERVE_DELAY cycles; the delay counter clears on entry.
REQ-020 SERVE -> PLAY: in the first PLAY cycle, ball_reset = 0, speed = +BASE_SPEED if serve_dir = +, else -BASE_SPEED; the magnitude register loads BASE_SPEED; the ramp counter clears.
REQ-021 PLAY speed ramp: every RAMP_PERIOD PLAY cycles, magnitude increments by 1, saturating at MAX_SPEED. The sign of speed is the serve sign and is held for the whole rally.
REQ-022 Goal detection: prev_x holds ball_x from the previous cycle, updated every cycle in every state. Left goal = prev_x 15 AND ball_x 0. Right goal = prev_x 0 AND ball_x 15. Detection is evaluated in PLAY only.
REQ-023 Left goal in PLAY: rscore += 1; serve_dir = + (next serve goes toward the conceding left player); next state POINT.
REQ-024 Right goal in PLAY: lscore += 1; serve_dir = -; next state POINT.
REQ-025 Any ball_x change other than a 15<->0 wrap is not a goal. Left and right goals are mutually exclusive by construction.
REQ-026 POINT: one cycle; ball_reset = 1, speed = 0. Next state is OVER if lscore = WIN_SCORE or rscore = WIN_SCORE, otherwise SERVE. Scores never exceed WIN_SCORE.
REQ-027 OVER: ball_reset = 1, speed = 0, game_over = 1, winner = (lscore = WIN_SCORE). Scores hold. A start edge clears scores, sets serve_dir = +, and moves to SERVE.
REQ-028 A start edge in SERVE, PLAY or POINT is ignored.
REQ-029 speed is never driven outside -15..+15 (no -16).

Reset
REQ-030 Reset takes priority over all other inputs. The cycle after reset is sampled high: state = IDLE, ball_reset = 1, speed = 0, lscore = rscore = 0, game_over = 0, winner = 0, serve_dir = +, all counters = 0, prev_x = 8.
REQ-031 Reset asserted mid-rally (any state) aborts the match with the same values as REQ-030. No score update occurs in that cycle, even if a goal condition is present.

Verification (SERVE_DELAY=4, RAMP_PERIOD=8, BASE_SPEED=4, MAX_SPEED=6, WIN_SCORE=2)
REQ-032 Reset, then start pulse -> ball_reset high exactly 4 cycles in SERVE, then ball_reset = 0 and speed = +4.
REQ-033 Hold PLAY for 40 cycles with no goal -> speed 4, then 5 after 8 cycles, then 6 after 16 cycles, and 6 thereafter (saturated).
REQ-034 In PLAY drive ball_x 15 then 0 -> rscore = 1, one POINT cycle, SERVE for 4 cycles, then speed = +4. Drive ball_x 0 then 15 -> lscore = 1, next serve speed = -4.
REQ-035 Two left goals -> rscore = 2, then OVER with game_over = 1, winner = 0. Start edge -> scores 0, SERVE entered.
REQ-036 Hold start high through PLAY; assert reset with ball_x transitioning 15 -> 0 on the same cycle -> IDLE, scores 0, no point counted; start held high does not re-launch a match until it goes low and high again.
